// File: rtl/reg_file.sv
// Sixteen-entry general register file with four combinational read ports,
// one write port, and a separate program-counter register.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] IR_ARn,
  input  logic [ADDR_W-1:0] IR_ARs,
  input  logic [ADDR_W-1:0] IR_ARm,
  input  logic [ADDR_W-1:0] mux_ARd_or_15,
  input  logic              CNTRL_write_en_ARd,
  input  logic [PC_W-1:0]   PC_next,
  input  logic [DATA_W-1:0] mux_ALU_result_or_DMEM_data,
  output logic [DATA_W-1:0] Rn,
  output logic [DATA_W-1:0] Rs,
  output logic [DATA_W-1:0] Rm,
  output logic [DATA_W-1:0] Rd,
  output logic [PC_W-1:0]   PC_out
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [PC_W-1:0]   pc_reg;

  // Each register owns its flop and decodes its own write select, so an
  // unknown address with the enable low can never reach any register.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_gpr
      logic              wr_sel;
      logic [DATA_W-1:0] q_reg;

      assign wr_sel = CNTRL_write_en_ARd && (mux_ARd_or_15 == ADDR_W'(gi));

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          q_reg <= '0;
        end else if (wr_sel) begin
          q_reg <= mux_ALU_result_or_DMEM_data;
        end
      end

      assign gpr_q[gi] = q_reg;
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= PC_next;
    end
  end

  // Reads come straight from the flops: no bypass of the in-flight write.
  assign Rn     = gpr_q[IR_ARn];
  assign Rs     = gpr_q[IR_ARs];
  assign Rm     = gpr_q[IR_ARm];
  assign Rd     = gpr_q[mux_ARd_or_15];
  assign PC_out = pc_reg;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: writes, port reads, PC tracking,
// no-bypass timing and asynchronous reset.
module tb_reg_file;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic [3:0]  IR_ARn, IR_ARs, IR_ARm, mux_ARd_or_15;
  logic        CNTRL_write_en_ARd;
  logic [15:0] PC_next;
  logic [31:0] mux_ALU_result_or_DMEM_data;
  logic [31:0] Rn, Rs, Rm, Rd;
  logic [15:0] PC_out;

  int err_cnt = 0;
  int chk_cnt = 0;

  reg_file dut (
    .CLOCK_50                    (CLOCK_50),
    .RESET_N                     (RESET_N),
    .IR_ARn                      (IR_ARn),
    .IR_ARs                      (IR_ARs),
    .IR_ARm                      (IR_ARm),
    .mux_ARd_or_15               (mux_ARd_or_15),
    .CNTRL_write_en_ARd          (CNTRL_write_en_ARd),
    .PC_next                     (PC_next),
    .mux_ALU_result_or_DMEM_data (mux_ALU_result_or_DMEM_data),
    .Rn                          (Rn),
    .Rs                          (Rs),
    .Rm                          (Rm),
    .Rd                          (Rd),
    .PC_out                      (PC_out)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0d (0x%08h) expected=%0d (0x%08h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One rising edge; PC_out must then equal the PC_next presented before it
  // (or 0 while reset is held). PC_next then advances by one.
  task automatic tick();
    logic [15:0] prev_pc;
    prev_pc = PC_next;
    @(posedge CLOCK_50);
    #1;
    if (RESET_N) check_eq("pc_follow", 32'(PC_out), 32'(prev_pc));
    else         check_eq("pc_in_rst", 32'(PC_out), 32'd0);
    PC_next = PC_next + 16'd1;
  endtask

  task automatic read4(input logic [3:0] an, input logic [3:0] as_, input logic [3:0] am,
                       input logic [3:0] ad);
    IR_ARn = an; IR_ARs = as_; IR_ARm = am; mux_ARd_or_15 = ad;
    #1;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    mux_ARd_or_15 = addr;
    mux_ALU_result_or_DMEM_data = data;
    CNTRL_write_en_ARd = 1'b1;
    tick();
    CNTRL_write_en_ARd = 1'b0;
    IR_ARn = addr;
    #1;
    check_eq($sformatf("wr_R%0d_rn", addr), Rn, data);
    check_eq($sformatf("wr_R%0d_rd", addr), Rd, data);
  endtask

  logic [3:0]  wr_addr [5] = '{4'd7, 4'd3, 4'd4, 4'd15, 4'd2};
  logic [31:0] wr_data [5] = '{32'd19, 32'd21, 32'd20, 32'd99, 32'd27};

  initial begin
    RESET_N = 1'b0;
    IR_ARn = '0; IR_ARs = '0; IR_ARm = '0; mux_ARd_or_15 = '0;
    CNTRL_write_en_ARd = 1'b0;
    PC_next = 16'd0;
    mux_ALU_result_or_DMEM_data = '0;

    // Reset state: every register and the PC read zero
    #7;
    for (int i = 0; i < 16; i++) begin
      IR_ARn = 4'(i);
      #1;
      check_eq($sformatf("rst_R%0d", i), Rn, 32'd0);
    end
    check_eq("rst_pc", 32'(PC_out), 32'd0);

    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    for (int i = 0; i < 5; i++) write_reg(wr_addr[i], wr_data[i]);

    // Independent read ports
    read4(4'd7, 4'd3, 4'd4, 4'd2);
    check_eq("rd1_rn", Rn, 32'd19);
    check_eq("rd1_rs", Rs, 32'd21);
    check_eq("rd1_rm", Rm, 32'd20);
    check_eq("rd1_rd", Rd, 32'd27);
    read4(4'd3, 4'd4, 4'd2, 4'd15);
    check_eq("rd2_rn", Rn, 32'd21);
    check_eq("rd2_rs", Rs, 32'd20);
    check_eq("rd2_rm", Rm, 32'd27);
    check_eq("rd2_rd", Rd, 32'd99);

    // Write enable low: R7 must keep 19
    mux_ARd_or_15 = 4'd7;
    mux_ALU_result_or_DMEM_data = 32'd55;
    CNTRL_write_en_ARd = 1'b0;
    repeat (3) tick();
    IR_ARn = 4'd7;
    #1;
    check_eq("noen_R7", Rn, 32'd19);

    // R0 is ordinary storage
    write_reg(4'd0, 32'h1234_5678);

    // No bypass: old value before the edge, new value after
    IR_ARn = 4'd3;
    mux_ARd_or_15 = 4'd3;
    mux_ALU_result_or_DMEM_data = 32'd5;
    CNTRL_write_en_ARd = 1'b1;
    #1;
    check_eq("bypass_pre", Rn, 32'd21);
    tick();
    CNTRL_write_en_ARd = 1'b0;
    check_eq("bypass_post", Rn, 32'd5);

    // Unknown write address with enable low alters nothing
    mux_ARd_or_15 = 'x;
    mux_ALU_result_or_DMEM_data = 32'hDEAD_BEEF;
    tick();
    read4(4'd0, 4'd15, 4'd2, 4'd4);
    check_eq("xaddr_R0", Rn, 32'h1234_5678);
    check_eq("xaddr_R15", Rs, 32'd99);
    check_eq("xaddr_R2", Rm, 32'd27);
    check_eq("xaddr_R4", Rd, 32'd20);

    // Asynchronous reset mid-cycle during an enabled write
    read4(4'd7, 4'd3, 4'd15, 4'd9);
    mux_ALU_result_or_DMEM_data = 32'd77;
    CNTRL_write_en_ARd = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("arst_rn", Rn, 32'd0);
    check_eq("arst_rs", Rs, 32'd0);
    check_eq("arst_rm", Rm, 32'd0);
    check_eq("arst_rd", Rd, 32'd0);
    check_eq("arst_pc", 32'(PC_out), 32'd0);
    tick();
    check_eq("arst_hold_rd", Rd, 32'd0);

    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    CNTRL_write_en_ARd = 1'b0;
    tick();
    IR_ARn = 4'd7;
    #1;
    check_eq("post_rst_R7", Rn, 32'd0);
    check_eq("post_rst_R9", Rd, 32'd0);

    write_reg(4'd9, 32'd77);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32: register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 4: register address width; the file SHALL hold 2**ADDR_W registers (16: R0..R15).
REQ-003 Parameter PC_W, default 16: program-counter width in bits.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 CLOCK_50  input  1  system clock; all state updates on the rising edge.
REQ-006 RESET_N  input  1  asynchronous active-low reset.
REQ-007 IR_ARn  input  ADDR_W  read address, port Rn.
REQ-008 IR_ARs  input  ADDR_W  read address, port Rs.
REQ-009 IR_ARm  input  ADDR_W  read address, port Rm.
REQ-010 mux_ARd_or_15  input  ADDR_W  write address; also read address of port Rd.
REQ-011 CNTRL_write_en_ARd  input  1  write enable for the register at mux_ARd_or_15.
REQ-012 PC_next  input  PC_W  next program-counter value.
REQ-013 mux_ALU_result_or_DMEM_data  input  DATA_W  write data.
REQ-014 Rn, Rs, Rm, Rd  output  DATA_W each  read data for IR_ARn, IR_ARs, IR_ARm and mux_ARd_or_15.
REQ-015 PC_out  output  PC_W  current program-counter register value.

Function
REQ-016 Storage SHALL be 16 general 32-bit registers R0..R15 plus one separate PC_W-bit PC register.
REQ-017 R0..R15 SHALL all be ordinary storage: R0 is writable and R15 is not aliased to the PC.
REQ-018 On each rising edge with CNTRL_write_en_ARd=1 and RESET_N=1, the register addressed by mux_ARd_or_15 SHALL load mux_ALU_result_or_DMEM_data.
REQ-019 With CNTRL_write_en_ARd=0, no general register SHALL change.
REQ-020 Each rising edge with RESET_N=1 SHALL load PC_next into the PC register unconditionally, independent of the write enable.
REQ-021 Rn, Rs, Rm and Rd SHALL be combinational (zero-latency) reads of the addressed registers.
REQ-022 PC_out SHALL equal the PC register.
REQ-023 The four read ports SHALL be independent; any or all may address the same register, including the register being written.
REQ-024 Reads SHALL have no write-through bypass: a read of the register being written returns the old value until the rising edge, then the new value.
REQ-025 A write is visible on all read ports immediately after the capturing edge (one-edge write latency).
REQ-026 X or Z on addresses while the write enable is 0 SHALL NOT alter any state.

Reset
REQ-027 RESET_N=0 SHALL immediately, without a clock edge, clear R0..R15 and the PC register to 0; consequently Rn/Rs/Rm/Rd read 0 and PC_out=0.
REQ-028 While RESET_N=0, writes and PC updates SHALL be blocked.
REQ-029 Releasing RESET_N SHALL allow normal operation from the next rising edge.
REQ-030 Asserting RESET_N mid-operation, including during an enabled write, SHALL discard the write and clear all state.

Verification
REQ-031 Reset, then write 19->R7, 21->R3, 20->R4, 99->R15, 27->R2 on consecutive edges with enable=1 -> each register holds its value after its edge.
REQ-032 Enable=0, IR_ARn=7, IR_ARs=3, IR_ARm=4, mux_ARd_or_15=2 -> Rn=19, Rs=21, Rm=20, Rd=27; then addresses 3/4/2/15 -> Rn=21, Rs=20, Rm=27, Rd=99.
REQ-033 PC_next incremented by 1 after every edge, starting from 0 -> PC_out follows PC_next one edge later; writes and the enable have no effect on PC_out.
REQ-034 Enable=0 with write data 55 to R7 over several edges -> R7 still reads 19.
REQ-035 Write 5 to R3 while IR_ARn=3 -> Rn reads 21 before the edge and 5 after it.
REQ-036 Assert RESET_N=0 between clock edges after the writes -> all read ports and PC_out go to 0 immediately and stay 0 until a write after reset is released.
